fp_acc: RTL and testbench
=========================

FP_ACC -- requirements
Module: fp_acc

Interface
REQ-001 SHALL have parameter INT_W, default 9, sign plus exponent width.
REQ-002 SHALL have parameter FRAC_W, default 23, stored fraction width.
REQ-003 SHALL have parameter DATA_W, default INT_W+FRAC_W, word width; format {sign, exponent bias 127, fraction}, same as multiplier product words.
REQ-004 SHALL have port i_clk, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port i_rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port i_clear, input, 1, abandons the current group and zeroes the accumulator.
REQ-007 SHALL have port i_in_valid, input, 1, product beat valid.
REQ-008 SHALL have port o_in_ready, output, 1, block accepts a beat.
REQ-009 SHALL have port i_data, input, DATA_W, product word from the multiplier stage.
REQ-010 SHALL have port i_last, input, 1, qualifies the final beat of a group.
REQ-011 SHALL have port o_out_valid, output, 1, group sum valid.
REQ-012 SHALL have port i_out_ready, input, 1, consumer accepts the sum.
REQ-013 SHALL have port o_data, output, DATA_W, accumulated sum.
REQ-014 SHALL have port o_count, output, 8, beats accumulated in the current group, saturating at 255.
REQ-015 SHALL have port o_ovf, output, 1, sticky overflow flag for the current group.

Function
REQ-016 SHALL implement FSM states S_ACC, S_ALIGN, S_NORM, S_OUT.
REQ-017 SHALL drive o_in_ready=1 only in S_ACC.
REQ-018 SHALL drive o_out_valid=1 only in S_OUT.
REQ-019 SHALL accept a beat on i_in_valid & o_in_ready: S_ACC->S_ALIGN; capture i_data and i_last; o_count increments.
REQ-020 In S_ALIGN, SHALL compare magnitudes, swap, and right-shift the smaller hidden-1 mantissa by the exponent difference into guard, round and sticky bits; shifts >=26 fold all bits into sticky; then S_ALIGN->S_NORM.
REQ-021 In S_NORM, SHALL add or subtract by sign; normalize (right 1 on carry, left by leading-zero count otherwise); round to nearest even; renormalize on rounding carry; write the accumulator.
REQ-022 From S_NORM, SHALL go to S_OUT if the captured last=1, else to S_ACC.
REQ-023 With the handshake cycle as cycle 0, o_out_valid SHALL first be high in cycle 3.
REQ-024 SHALL sustain a throughput of one beat per 3 cycles.
REQ-025 In S_OUT, SHALL hold o_data, o_count and o_ovf stable until i_out_ready=1.
REQ-026 On that S_OUT handshake, SHALL clear the accumulator to +0 and zero o_count and o_ovf, then S_OUT->S_ACC.
REQ-027 SHALL treat an input with exponent 0 as zero, ignoring its fraction.
REQ-028 SHALL not support NaN, Inf or denormal inputs; their results are don't-care, except for the overflow rule in REQ-031.
REQ-029 SHALL make an exact-zero result +0 (0x00000000); a nonzero result takes the sign of the larger magnitude.
REQ-030 SHALL flush a result whose exponent would fall below 1 to +0, with no flag.
REQ-031 SHALL saturate a result whose exponent would exceed 254 to sign|0x7F800000 and set o_ovf.
REQ-032 Once o_ovf is set, the accumulator SHALL hold the infinity for the rest of the group.
REQ-033 i_clear=1 in any state SHALL, next cycle, give state S_ACC, accumulator +0, o_count=0, o_ovf=0, o_out_valid=0.
REQ-034 i_clear SHALL have priority over any same-cycle handshake; the beat or sum is dropped.
REQ-035 SHALL make o_data equal the accumulator register at all times.

Reset
REQ-036 i_rst=1 SHALL set state S_ACC, accumulator 0x00000000, o_count=0, o_ovf=0, o_out_valid=0, o_in_ready=1 (after the edge).
REQ-037 i_rst SHALL have priority over i_clear and over all handshakes.
REQ-038 i_rst asserted mid-operation SHALL discard in-flight data.

Verification
REQ-039 Single beat 0x3F800000, last=1 -> cycle 3: o_out_valid=1, o_data=0x3F800000, o_count=1, o_ovf=0.
REQ-040 Beats 0x3F800000, 0x40000000, 0xBF000000 (last) -> o_data=0x40200000, o_count=3.
REQ-041 Beats 0x3F800000, 0xBF800000 (last) -> o_data=0x00000000; then 0x3F800000, 0x33800000 (last) -> 0x3F800000 (tie to even); then 0x3F800000, 0x33800001 (last) -> 0x3F800001.
REQ-042 Beats 0x7F7FFFFF, 0x7F7FFFFF, 0x3F800000 (last) -> o_data=0x7F800000, o_ovf=1.
REQ-043 Hold i_out_ready=0 for 5 cycles in S_OUT -> o_data, o_count stable, o_in_ready=0; handshake -> next cycle o_in_ready=1, o_count=0.
REQ-044 i_clear in S_ALIGN, and i_rst in S_NORM -> next cycle S_ACC, o_data=0, o_count=0; the next group sum excludes the dropped beat.

Source files
------------

// File: rtl/fp_acc.sv
// fp_acc: streaming single-precision accumulator for multiplier product words.
// Each accepted beat is added to a running sum over three cycles:
// capture, align, then add/normalize/round. The sum is offered on the
// output when the beat marked last has been folded in.
module fp_acc #(
  parameter int INT_W  = 9,
  parameter int FRAC_W = 23,
  parameter int DATA_W = INT_W + FRAC_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [7:0]        o_count,
  output logic              o_ovf
);

  localparam int EXP_W = INT_W - 1;        // biased exponent field
  localparam int MAN_W = FRAC_W + 1;       // mantissa with hidden one
  localparam int EXT_W = MAN_W + 3;        // mantissa plus guard, round, sticky
  localparam int SUM_W = EXT_W + 1;        // one carry bit for addition
  localparam int SH_W  = MAN_W + 2;        // aligned mantissa plus guard and round
  localparam int XW    = EXP_W + 2;        // signed working exponent
  localparam int LZ_W  = $clog2(EXT_W + 1);

  localparam logic [EXP_W-1:0] EXP_INF    = '1;
  localparam logic [EXP_W-1:0] FOLD_SHIFT = EXP_W'(SH_W);

  typedef enum logic [1:0] {S_ACC, S_ALIGN, S_NORM, S_OUT} state_t;

  state_t             state_reg, state_next;
  logic [DATA_W-1:0]  acc_reg, acc_next;
  logic [DATA_W-1:0]  beat_reg, beat_next;
  logic               last_reg, last_next;
  logic [7:0]         count_reg, count_next;
  logic               ovf_reg, ovf_next;
  logic               sign_l_reg, sign_l_next;
  logic               sign_s_reg, sign_s_next;
  logic [EXP_W-1:0]   exp_l_reg, exp_l_next;
  logic [MAN_W-1:0]   man_l_reg, man_l_next;
  logic [EXT_W-1:0]   man_s_reg, man_s_next;

  // Alignment stage signals
  logic [EXP_W-1:0]   a_exp, b_exp, al_exp_l, al_exp_s, al_diff;
  logic [MAN_W-1:0]   a_man, b_man, al_man_l, al_man_s;
  logic               al_sign_l, al_sign_s, b_larger;
  logic [2*SH_W-1:0]  al_shifted;
  logic [EXT_W-1:0]   al_ext_s;

  // Add / normalize / round stage signals
  logic [SUM_W-1:0]   nm_sum;
  logic [EXT_W-1:0]   nm_norm;
  logic [LZ_W-1:0]    nm_lz;
  logic [XW-1:0]      nm_exp;
  logic               nm_round_up;
  logic [MAN_W:0]     nm_rnd;
  logic [FRAC_W-1:0]  nm_frac;
  logic [DATA_W-1:0]  nm_result;
  logic               nm_ovf;

  // Order the accumulator and the captured beat by magnitude and shift the
  // smaller mantissa right; bits shifted past the round position become sticky.
  always_comb begin
    a_exp = acc_reg[DATA_W-2 -: EXP_W];
    b_exp = beat_reg[DATA_W-2 -: EXP_W];
    // A zero exponent means zero regardless of the fraction bits
    a_man = (a_exp == '0) ? '0 : {1'b1, acc_reg[FRAC_W-1:0]};
    b_man = (b_exp == '0) ? '0 : {1'b1, beat_reg[FRAC_W-1:0]};
    b_larger = {b_exp, b_man} > {a_exp, a_man};

    if (b_larger) begin
      al_sign_l = beat_reg[DATA_W-1];
      al_exp_l  = b_exp;
      al_man_l  = b_man;
      al_sign_s = acc_reg[DATA_W-1];
      al_exp_s  = a_exp;
      al_man_s  = a_man;
    end else begin
      al_sign_l = acc_reg[DATA_W-1];
      al_exp_l  = a_exp;
      al_man_l  = a_man;
      al_sign_s = beat_reg[DATA_W-1];
      al_exp_s  = b_exp;
      al_man_s  = b_man;
    end

    al_diff    = al_exp_l - al_exp_s;
    al_shifted = {al_man_s, 2'b00, {SH_W{1'b0}}} >> al_diff;
    // Past the round position nothing but stickiness survives
    if (al_diff >= FOLD_SHIFT) begin
      al_ext_s = {{(EXT_W-1){1'b0}}, |al_man_s};
    end else begin
      al_ext_s = {al_shifted[2*SH_W-1 -: SH_W], |al_shifted[SH_W-1:0]};
    end
  end

  // Signed-magnitude add, normalize, round to nearest even, and range-check
  // the exponent (flush to +0 below the normal range, saturate above it).
  always_comb begin
    if (sign_l_reg == sign_s_reg) begin
      nm_sum = {1'b0, man_l_reg, 3'b000} + {1'b0, man_s_reg};
    end else begin
      nm_sum = {1'b0, man_l_reg, 3'b000} - {1'b0, man_s_reg};
    end

    // Ascending scan: the last set bit seen is the leading one
    nm_lz = '0;
    for (int i = 0; i < EXT_W; i++) begin
      if (nm_sum[i]) begin
        nm_lz = LZ_W'(EXT_W - 1 - i);
      end
    end

    if (nm_sum[SUM_W-1]) begin
      nm_norm = {nm_sum[SUM_W-1:2], nm_sum[1] | nm_sum[0]};
      nm_exp  = XW'(exp_l_reg) + XW'(1);
    end else begin
      nm_norm = nm_sum[EXT_W-1:0] << nm_lz;
      nm_exp  = XW'(exp_l_reg) - XW'(nm_lz);
    end

    nm_round_up = nm_norm[2] & (nm_norm[3] | nm_norm[1] | nm_norm[0]);
    nm_rnd      = {1'b0, nm_norm[EXT_W-1:3]} + {{MAN_W{1'b0}}, nm_round_up};
    if (nm_rnd[MAN_W]) begin
      // Rounding carried out of the mantissa: value is now exactly 2^(e+1)
      nm_exp  = nm_exp + XW'(1);
      nm_frac = nm_rnd[FRAC_W:1];
    end else begin
      nm_frac = nm_rnd[FRAC_W-1:0];
    end

    nm_ovf    = 1'b0;
    nm_result = {sign_l_reg, nm_exp[EXP_W-1:0], nm_frac};
    if (nm_sum == '0 || nm_exp[XW-1] || nm_exp == '0) begin
      nm_result = '0;
    end else if (nm_exp[XW-2:0] >= {1'b0, EXP_INF}) begin
      nm_result = {sign_l_reg, EXP_INF, {FRAC_W{1'b0}}};
      nm_ovf    = 1'b1;
    end
  end

  // Next-state, handshake outputs and register updates for every state.
  always_comb begin
    state_next  = state_reg;
    acc_next    = acc_reg;
    beat_next   = beat_reg;
    last_next   = last_reg;
    count_next  = count_reg;
    ovf_next    = ovf_reg;
    sign_l_next = sign_l_reg;
    sign_s_next = sign_s_reg;
    exp_l_next  = exp_l_reg;
    man_l_next  = man_l_reg;
    man_s_next  = man_s_reg;
    o_in_ready  = (state_reg == S_ACC);
    o_out_valid = (state_reg == S_OUT);

    case (state_reg)
      S_ACC: begin
        if (i_in_valid) begin
          beat_next  = i_data;
          last_next  = i_last;
          if (count_reg != 8'hFF) begin
            count_next = count_reg + 8'd1;
          end
          state_next = S_ALIGN;
        end
      end
      S_ALIGN: begin
        sign_l_next = al_sign_l;
        sign_s_next = al_sign_s;
        exp_l_next  = al_exp_l;
        man_l_next  = al_man_l;
        man_s_next  = al_ext_s;
        state_next  = S_NORM;
      end
      S_NORM: begin
        // After an overflow the accumulator keeps its infinity for the group
        if (!ovf_reg) begin
          acc_next = nm_result;
          ovf_next = nm_ovf;
        end
        state_next = last_reg ? S_OUT : S_ACC;
      end
      S_OUT: begin
        if (i_out_ready) begin
          acc_next   = '0;
          count_next = '0;
          ovf_next   = 1'b0;
          state_next = S_ACC;
        end
      end
      default: state_next = S_ACC;
    endcase

    // Clear abandons whatever is in flight, including a same-cycle handshake
    if (i_clear) begin
      state_next = S_ACC;
      acc_next   = '0;
      count_next = '0;
      ovf_next   = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= S_ACC;
    end else begin
      state_reg <= state_next;
    end
  end

  // Accumulator, group status and pipeline registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_reg    <= '0;
      beat_reg   <= '0;
      last_reg   <= 1'b0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
      sign_l_reg <= 1'b0;
      sign_s_reg <= 1'b0;
      exp_l_reg  <= '0;
      man_l_reg  <= '0;
      man_s_reg  <= '0;
    end else begin
      acc_reg    <= acc_next;
      beat_reg   <= beat_next;
      last_reg   <= last_next;
      count_reg  <= count_next;
      ovf_reg    <= ovf_next;
      sign_l_reg <= sign_l_next;
      sign_s_reg <= sign_s_next;
      exp_l_reg  <= exp_l_next;
      man_l_reg  <= man_l_next;
      man_s_reg  <= man_s_next;
    end
  end

  assign o_data  = acc_reg;
  assign o_count = count_reg;
  assign o_ovf   = ovf_reg;

endmodule

// File: tb/tb_fp_acc.sv
// Bench for fp_acc: directed vector table, hand-written timing/control
// sequences, and random groups checked against an exact-arithmetic model.
module tb_fp_acc;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_clear = 1'b0;
  logic        i_in_valid = 1'b0;
  logic        o_in_ready;
  logic [31:0] i_data = '0;
  logic        i_last = 1'b0;
  logic        o_out_valid;
  logic        i_out_ready = 1'b0;
  logic [31:0] o_data;
  logic [7:0]  o_count;
  logic        o_ovf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  fp_acc dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (i_clear),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_data      (i_data),
    .i_last      (i_last),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_data      (o_data),
    .o_count     (o_count),
    .o_ovf       (o_ovf)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    int          n;
    logic [31:0] b0, b1, b2;
    logic [31:0] exp_d;
    logic [7:0]  exp_c;
    logic        exp_o;
  } vec_t;

  function automatic vec_t mk(input int n, input logic [31:0] b0, b1, b2,
                              input logic [31:0] d, input logic [7:0] c, input logic o);
    vec_t v;
    v.n = n; v.b0 = b0; v.b1 = b1; v.b2 = b2;
    v.exp_d = d; v.exp_c = c; v.exp_o = o;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Exact sum of two words rounded to nearest even; bit 32 flags overflow.
  function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic [319:0] ma, mb, mag, q, rem, half;
    int ea, eb, e0, p, sh, e;
    logic s;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 0 && eb == 0) return 33'd0;
    if (ea == 0) return {1'b0, b};
    if (eb == 0) return {1'b0, a};
    e0 = (ea < eb) ? ea : eb;
    ma = '0; ma[23:0] = {1'b1, a[22:0]}; ma = ma << (ea - e0);
    mb = '0; mb[23:0] = {1'b1, b[22:0]}; mb = mb << (eb - e0);
    if (a[31] == b[31]) begin
      mag = ma + mb; s = a[31];
    end else if (ma >= mb) begin
      mag = ma - mb; s = a[31];
    end else begin
      mag = mb - ma; s = b[31];
    end
    if (mag == '0) return 33'd0;
    p = 0;
    for (int i = 0; i < 320; i++) if (mag[i]) p = i;
    e = e0 + p - 23;
    if (p > 23) begin
      sh = p - 23;
      q = mag >> sh;
      rem = mag - (q << sh);
      half = 320'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q[24]) begin
        q = q >> 1;
        e = e + 1;
      end
    end else begin
      q = mag << (23 - p);
    end
    if (e > 254) return {1'b1, s, 8'hFF, 23'd0};
    if (e < 1) return 33'd0;
    return {1'b0, s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    int sel;
    w = $urandom;
    sel = int'($urandom_range(0, 15));
    if (sel == 0) begin
      w[30:23] = 8'd0;
    end else if (sel < 5) begin
      w[30:23] = 8'(127 + $urandom_range(0, 2));
      w[15:0] = 16'd0;
    end else begin
      w[30:23] = 8'($urandom_range(100, 154));
    end
    return w;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!o_in_ready && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_in_ready) chk("in_ready_timeout", {31'd0, o_in_ready}, 32'd1);
  endtask

  task automatic send(input logic [31:0] d, input logic last, input int gap);
    repeat (gap) @(negedge i_clk);
    wait_ready();
    i_in_valid = 1'b1;
    i_data = d;
    i_last = last;
    @(negedge i_clk);
    i_in_valid = 1'b0;
    i_last = 1'b0;
  endtask

  task automatic get_sum(output logic [31:0] d, output logic [7:0] c, output logic o,
                         input int delay);
    int n = 0;
    d = '0; c = '0; o = 1'b0;
    while (!o_out_valid && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_out_valid) begin
      chk("out_valid_timeout", {31'd0, o_out_valid}, 32'd1);
    end else begin
      d = o_data; c = o_count; o = o_ovf;
      repeat (delay) @(negedge i_clk);
      i_out_ready = 1'b1;
      @(negedge i_clk);
      i_out_ready = 1'b0;
    end
  endtask

  vec_t tbl[14];

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, acc, w;
    logic [7:0]  c;
    logic        o, m_ovf;
    logic [32:0] r;
    int          n, t[4];
    logic [31:0] tp_beats[4];

    tbl[0]  = mk(1, 32'h3F800000, 32'h0, 32'h0, 32'h3F800000, 8'd1, 1'b0);
    tbl[1]  = mk(3, 32'h3F800000, 32'h40000000, 32'hBF000000, 32'h40200000, 8'd3, 1'b0);
    tbl[2]  = mk(2, 32'h3F800000, 32'hBF800000, 32'h0, 32'h00000000, 8'd2, 1'b0);
    tbl[3]  = mk(2, 32'h3F800000, 32'h33800000, 32'h0, 32'h3F800000, 8'd2, 1'b0);
    tbl[4]  = mk(2, 32'h3F800000, 32'h33800001, 32'h0, 32'h3F800001, 8'd2, 1'b0);
    tbl[5]  = mk(3, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h3F800000, 32'h7F800000, 8'd3, 1'b1);
    tbl[6]  = mk(2, 32'h00800001, 32'h80800000, 32'h0, 32'h00000000, 8'd2, 1'b0);
    tbl[7]  = mk(2, 32'hFF7FFFFF, 32'hFF7FFFFF, 32'h0, 32'hFF800000, 8'd2, 1'b1);
    tbl[8]  = mk(2, 32'h40400000, 32'h00123456, 32'h0, 32'h40400000, 8'd2, 1'b0);
    tbl[9]  = mk(2, 32'h3F800000, 32'h3F800000, 32'h0, 32'h40000000, 8'd2, 1'b0);
    tbl[10] = mk(2, 32'h3F800000, 32'h33C00000, 32'h0, 32'h3F800001, 8'd2, 1'b0);
    tbl[11] = mk(2, 32'h3F800001, 32'h33800000, 32'h0, 32'h3F800002, 8'd2, 1'b0);
    tbl[12] = mk(3, 32'h3F800000, 32'hBF800000, 32'hC0000000, 32'hC0000000, 8'd3, 1'b0);
    tbl[13] = mk(2, 32'h40000000, 32'hBF800000, 32'h0, 32'h3F800000, 8'd2, 1'b0);

    // Reset state
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    chk("reset_in_ready", {31'd0, o_in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, o_out_valid}, 32'd0);
    chk("reset_data", o_data, 32'h0);
    chk("reset_count", {24'd0, o_count}, 32'd0);
    chk("reset_ovf", {31'd0, o_ovf}, 32'd0);

    // Latency: handshake cycle 0, sum valid in cycle 3
    i_in_valid = 1'b1; i_data = 32'h3F800000; i_last = 1'b1;
    @(negedge i_clk);
    i_in_valid = 1'b0; i_last = 1'b0;
    chk("lat_c1_valid", {31'd0, o_out_valid}, 32'd0);
    chk("lat_c1_ready", {31'd0, o_in_ready}, 32'd0);
    @(negedge i_clk);
    chk("lat_c2_valid", {31'd0, o_out_valid}, 32'd0);
    @(negedge i_clk);
    chk("lat_c3_valid", {31'd0, o_out_valid}, 32'd1);
    chk("lat_c3_data", o_data, 32'h3F800000);
    chk("lat_c3_count", {24'd0, o_count}, 32'd1);
    chk("lat_c3_ovf", {31'd0, o_ovf}, 32'd0);

    // Stall in S_OUT for 5 cycles, then handshake
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      chk("hold_data", o_data, 32'h3F800000);
      chk("hold_count", {24'd0, o_count}, 32'd1);
      chk("hold_ready", {31'd0, o_in_ready}, 32'd0);
    end
    i_out_ready = 1'b1;
    @(negedge i_clk);
    i_out_ready = 1'b0;
    chk("post_hs_ready", {31'd0, o_in_ready}, 32'd1);
    chk("post_hs_count", {24'd0, o_count}, 32'd0);
    chk("post_hs_data", o_data, 32'h0);

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].n > 0) send(tbl[i].b0, tbl[i].n == 1, 0);
      if (tbl[i].n > 1) send(tbl[i].b1, tbl[i].n == 2, 0);
      if (tbl[i].n > 2) send(tbl[i].b2, 1'b1, 0);
      get_sum(d, c, o, 0);
      $display("vec %0d data=%h count=%0d ovf=%0b", i, d, c, o);
      chk("vec_data", d, tbl[i].exp_d);
      chk("vec_count", {24'd0, c}, {24'd0, tbl[i].exp_c});
      chk("vec_ovf", {31'd0, o}, {31'd0, tbl[i].exp_o});
    end

    // Clear during S_ALIGN drops the in-flight beat
    wait_ready();
    i_in_valid = 1'b1; i_data = 32'h3F800000; i_last = 1'b0;
    @(negedge i_clk);
    i_in_valid = 1'b0;
    i_clear = 1'b1;
    @(negedge i_clk);
    i_clear = 1'b0;
    chk("clr_align_ready", {31'd0, o_in_ready}, 32'd1);
    chk("clr_align_data", o_data, 32'h0);
    chk("clr_align_count", {24'd0, o_count}, 32'd0);
    send(32'h40000000, 1'b1, 0);
    get_sum(d, c, o, 0);
    $display("clear-align group data=%h count=%0d", d, c);
    chk("clr_align_sum", d, 32'h40000000);
    chk("clr_align_sum_count", {24'd0, c}, 32'd1);

    // Reset during S_NORM discards the beat
    wait_ready();
    i_in_valid = 1'b1; i_data = 32'h3F800000; i_last = 1'b0;
    @(negedge i_clk);
    i_in_valid = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("rst_norm_ready", {31'd0, o_in_ready}, 32'd1);
    chk("rst_norm_valid", {31'd0, o_out_valid}, 32'd0);
    chk("rst_norm_data", o_data, 32'h0);
    chk("rst_norm_count", {24'd0, o_count}, 32'd0);
    send(32'h40000000, 1'b1, 0);
    get_sum(d, c, o, 0);
    $display("reset-norm group data=%h count=%0d", d, c);
    chk("rst_norm_sum", d, 32'h40000000);
    chk("rst_norm_sum_count", {24'd0, c}, 32'd1);

    // Clear beats a same-cycle input handshake
    i_in_valid = 1'b1; i_data = 32'h3F800000; i_last = 1'b1; i_clear = 1'b1;
    @(negedge i_clk);
    i_in_valid = 1'b0; i_last = 1'b0; i_clear = 1'b0;
    chk("clr_hs_ready", {31'd0, o_in_ready}, 32'd1);
    chk("clr_hs_count", {24'd0, o_count}, 32'd0);

    // Clear beats a same-cycle output handshake
    send(32'h3F800000, 1'b1, 0);
    repeat (2) @(negedge i_clk);
    chk("clr_out_valid_before", {31'd0, o_out_valid}, 32'd1);
    i_clear = 1'b1; i_out_ready = 1'b1;
    @(negedge i_clk);
    i_clear = 1'b0; i_out_ready = 1'b0;
    chk("clr_out_valid", {31'd0, o_out_valid}, 32'd0);
    chk("clr_out_data", o_data, 32'h0);
    chk("clr_out_count", {24'd0, o_count}, 32'd0);

    // Throughput: valid held high, one acceptance every three cycles
    tp_beats[0] = 32'h3F800000; tp_beats[1] = 32'h40000000;
    tp_beats[2] = 32'h40400000; tp_beats[3] = 32'h40800000;
    i_in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_data = tp_beats[k];
      i_last = (k == 3);
      wait_ready();
      t[k] = cyc;
      @(negedge i_clk);
    end
    i_in_valid = 1'b0; i_last = 1'b0;
    for (int k = 1; k < 4; k++) chk("tput_gap", 32'(t[k] - t[k-1]), 32'd3);
    get_sum(d, c, o, 0);
    $display("throughput group data=%h count=%0d", d, c);
    chk("tput_sum", d, 32'h41200000);
    chk("tput_count", {24'd0, c}, 32'd4);

    // Count saturation at 255
    acc = '0; m_ovf = 1'b0;
    for (int k = 0; k < 257; k++) begin
      r = ref_add(acc, 32'h3F800000);
      acc = r[31:0];
      send(32'h3F800000, k == 256, 0);
    end
    get_sum(d, c, o, 0);
    $display("saturation group data=%h count=%0d", d, c);
    chk("sat_count", {24'd0, c}, 32'd255);
    chk("sat_data", d, acc);

    // Random groups against the exact-arithmetic model
    for (int g = 0; g < 40; g++) begin
      n = int'($urandom_range(1, 6));
      acc = '0; m_ovf = 1'b0;
      for (int k = 0; k < n; k++) begin
        w = rand_word();
        if (!m_ovf) begin
          r = ref_add(acc, w);
          acc = r[31:0];
          m_ovf = r[32];
        end
        send(w, k == n - 1, int'($urandom_range(0, 2)));
      end
      get_sum(d, c, o, int'($urandom_range(0, 3)));
      $display("rand %0d beats=%0d data=%h model=%h count=%0d ovf=%0b", g, n, d, acc, c, o);
      chk("rand_data", d, acc);
      chk("rand_count", {24'd0, c}, 32'(n));
      chk("rand_ovf", {31'd0, o}, {31'd0, m_ovf});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
